// File: rtl/pl0_console_uart.sv
// Console bridge between the board UART pins and the PL/0 machine's character port.
// RX: synchronized 8N1 deserializer producing one-cycle byte strobes.
// TX: byte FIFO feeding a registered 8N1 serializer with gap-free back-to-back frames.
module pl0_console_uart #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned TX_FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] cpu_char_in,
  output logic       cpu_char_in_valid,
  input  logic [7:0] cpu_char_out,
  input  logic       cpu_char_out_valid,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AW    = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- RX path ----------------
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic             rx_strobe_c, rx_ferr_c, rx_mid_c;

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state          <= RX_IDLE;
      rx_cnt            <= '0;
      rx_shift          <= '0;
      rx_bit            <= '0;
      cpu_char_in       <= '0;
      cpu_char_in_valid <= 1'b0;
      rx_frame_err      <= 1'b0;
    end else begin
      rx_state          <= rx_state_n;
      rx_cnt            <= rx_cnt_n;
      rx_shift          <= rx_shift_n;
      rx_bit            <= rx_bit_n;
      cpu_char_in_valid <= rx_strobe_c;
      if (rx_strobe_c) cpu_char_in <= rx_shift;
      rx_frame_err      <= rx_frame_err | rx_ferr_c;
    end
  end

  // RX next-state: sample each bit when the counter reaches its mid-bit point
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_shift_n  = rx_shift;
    rx_bit_n    = rx_bit;
    rx_strobe_c = 1'b0;
    rx_ferr_c   = 1'b0;
    rx_mid_c    = (rx_cnt == CNT_W'(1));
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_BIT;
        end
      end
      RX_START: begin
        if (!rx_mid_c) begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end else if (!rx_sync) begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = FULL_BIT;
          rx_bit_n   = '0;
        end else begin
          rx_state_n = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!rx_mid_c) begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end else begin
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_cnt_n   = FULL_BIT;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (!rx_mid_c) begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end else if (rx_sync) begin
          rx_strobe_c = 1'b1;
          rx_state_n  = RX_IDLE;
        end else begin
          rx_ferr_c  = 1'b1;
          rx_state_n = RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- TX path ----------------
  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             fifo_empty_c, fifo_full_c, push_c, pop_c;
  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic             txd_n, tx_busy_n;

  assign fifo_empty_c = (wr_ptr == rd_ptr);
  assign fifo_full_c  = ((wr_ptr ^ rd_ptr) == PW'(TX_FIFO_DEPTH));
  assign push_c       = cpu_char_out_valid && !fifo_full_c;
  assign wr_ptr_n     = wr_ptr + PW'(push_c);
  assign rd_ptr_n     = rd_ptr + PW'(pop_c);

  // FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr[AW-1:0]] <= cpu_char_out;
  end

  // TX state, pointers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      tx_bit      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      tx_state    <= tx_state_n;
      tx_cnt      <= tx_cnt_n;
      tx_shift    <= tx_shift_n;
      tx_bit      <= tx_bit_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      uart_txd    <= txd_n;
      tx_busy     <= tx_busy_n;
      tx_overflow <= tx_overflow | (cpu_char_out_valid & fifo_full_c);
    end
  end

  // TX next-state: each bit held CLKS_PER_BIT cycles; next byte popped at end of stop
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    txd_n      = uart_txd;
    pop_c      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (!fifo_empty_c) begin
          pop_c      = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
          tx_cnt_n   = LAST_BIT;
          tx_state_n = TX_START;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CNT_W'(1);
        end else begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = LAST_BIT;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CNT_W'(1);
        end else begin
          tx_cnt_n = LAST_BIT;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - CNT_W'(1);
        end else if (!fifo_empty_c) begin
          pop_c      = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
          tx_cnt_n   = LAST_BIT;
          tx_state_n = TX_START;
          txd_n      = 1'b0;
        end else begin
          tx_state_n = TX_IDLE;
          txd_n      = 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    tx_busy_n = (tx_state_n != TX_IDLE) || (wr_ptr_n != rd_ptr_n);
  end

endmodule

// File: tb/tb_pl0_console_uart.sv
// Directed bench for pl0_console_uart with CLKS_PER_BIT=8 and a 16-deep TX FIFO.
module tb_pl0_console_uart;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] cpu_char_in;
  logic       cpu_char_in_valid;
  logic [7:0] cpu_char_out;
  logic       cpu_char_out_valid;
  logic       tx_busy;
  logic       tx_overflow;
  logic       rx_frame_err;

  pl0_console_uart #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_rxd           (uart_rxd),
    .uart_txd           (uart_txd),
    .cpu_char_in        (cpu_char_in),
    .cpu_char_in_valid  (cpu_char_in_valid),
    .cpu_char_out       (cpu_char_out),
    .cpu_char_out_valid (cpu_char_out_valid),
    .tx_busy            (tx_busy),
    .tx_overflow        (tx_overflow),
    .rx_frame_err       (rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // RX strobe observer
  int         rx_cnt = 0;
  logic [7:0] rx_last = '0;
  int         rx_cyc = 0;
  // TX line observer
  logic [7:0] tx_q[$];
  logic       tx_stop_q[$];
  int         tx_fall_q[$];
  int         tx_low_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cpu_char_in_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = cpu_char_in;
      rx_cyc  = cyc;
    end
    if (!uart_txd) tx_low_cnt = tx_low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial frame on uart_rxd; caller is aligned 1 time unit after a rising edge
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop_bit;
    tick(CPB);
    uart_rxd = 1'b1;
    tick(CPB);
  endtask

  // Decodes frames on uart_txd by sampling at mid-bit
  initial begin : tx_monitor
    logic [7:0] b;
    logic       st_ok;
    int         f;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && !uart_txd) begin
        f = cyc;
        tick(CPB / 2);
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          b[i] = uart_txd;
        end
        tick(CPB);
        st_ok = uart_txd;
        tx_q.push_back(b);
        tx_stop_q.push_back(st_ok);
        tx_fall_q.push_back(f);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, p0, base;
    logic [7:0] exp_b;
    reset              = 1'b1;
    uart_rxd           = 1'b1;
    cpu_char_out       = '0;
    cpu_char_out_valid = 1'b0;
    tick(3);
    check("rst_txd",   32'(uart_txd), 32'h1);
    check("rst_char",  32'(cpu_char_in), 32'h0);
    check("rst_valid", 32'(cpu_char_in_valid), 32'h0);
    check("rst_busy",  32'(tx_busy), 32'h0);
    check("rst_ovf",   32'(tx_overflow), 32'h0);
    check("rst_ferr",  32'(rx_frame_err), 32'h0);
    reset = 1'b0;
    tick(5);

    // Clean RX frame 0x41 with latency measured from the falling edge
    c0 = cyc;
    uart_send(8'h41, 1'b1);
    tick(10);
    check("rx41_count",   32'(rx_cnt), 32'd1);
    check("rx41_data",    32'(rx_last), 32'h41);
    check("rx41_latency", 32'(rx_cyc - c0), 32'd79);
    check("rx41_ferr",    32'(rx_frame_err), 32'h0);

    // Short low glitch produces nothing, next frame still received
    base = rx_cnt;
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(20);
    check("glitch_none", 32'(rx_cnt), 32'(base));
    uart_send(8'h5A, 1'b1);
    tick(10);
    check("rx5a_count", 32'(rx_cnt), 32'(base + 1));
    check("rx5a_data",  32'(rx_last), 32'h5A);

    // Bad stop bit: sticky error, no strobe, output holds; recovery frame
    base = rx_cnt;
    uart_send(8'h33, 1'b0);
    tick(20);
    check("ferr_set",    32'(rx_frame_err), 32'h1);
    check("ferr_nostb",  32'(rx_cnt), 32'(base));
    check("ferr_hold",   32'(cpu_char_in), 32'h5A);
    uart_send(8'h34, 1'b1);
    tick(10);
    check("rx34_count",  32'(rx_cnt), 32'(base + 1));
    check("rx34_data",   32'(rx_last), 32'h34);
    check("ferr_sticky", 32'(rx_frame_err), 32'h1);

    // Three back-to-back TX bytes
    check("tx_q_empty0", 32'(tx_q.size()), 32'd0);
    p0 = cyc;
    cpu_char_out_valid = 1'b1;
    cpu_char_out = 8'h48; tick(1);
    cpu_char_out = 8'h69; tick(1);
    cpu_char_out = 8'h0A; tick(1);
    cpu_char_out_valid = 1'b0;
    check("tx_busy_on", 32'(tx_busy), 32'h1);
    tick(3 * 10 * CPB + 10);
    check("tx3_count", 32'(tx_q.size()), 32'd3);
    if (tx_q.size() == 3) begin
      check("tx3_b0", 32'(tx_q[0]), 32'h48);
      check("tx3_b1", 32'(tx_q[1]), 32'h69);
      check("tx3_b2", 32'(tx_q[2]), 32'h0A);
      check("tx3_stop", 32'({tx_stop_q[0], tx_stop_q[1], tx_stop_q[2]}), 32'h7);
      check("tx3_latency", 32'(tx_fall_q[0] - p0), 32'd2);
      check("tx3_gap01", 32'(tx_fall_q[1] - tx_fall_q[0]), 32'(10 * CPB));
      check("tx3_gap12", 32'(tx_fall_q[2] - tx_fall_q[1]), 32'(10 * CPB));
    end
    check("tx3_idle", 32'(tx_busy), 32'h0);
    check("tx3_ovf",  32'(tx_overflow), 32'h0);

    // Overflow: 18 pushes into a 16-deep FIFO while TX is idle
    tx_q.delete(); tx_stop_q.delete(); tx_fall_q.delete();
    for (int i = 0; i < 18; i++) begin
      cpu_char_out_valid = 1'b1;
      cpu_char_out = 8'(i);
      tick(1);
    end
    cpu_char_out_valid = 1'b0;
    check("ovf_set", 32'(tx_overflow), 32'h1);
    tick(18 * 10 * CPB + 20);
    check("ovf_count", 32'(tx_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      exp_b = 8'(i);
      if (i < tx_q.size()) check($sformatf("ovf_b%0d", i), 32'(tx_q[i]), 32'(exp_b));
    end
    check("ovf_idle",   32'(tx_busy), 32'h0);
    check("ovf_sticky", 32'(tx_overflow), 32'h1);

    // Reset in the middle of a TX frame with a second byte queued
    cpu_char_out_valid = 1'b1;
    cpu_char_out = 8'hA5; tick(1);
    cpu_char_out = 8'h3C; tick(1);
    cpu_char_out_valid = 1'b0;
    tick(4 * CPB);
    check("mid_busy", 32'(tx_busy), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_txd",  32'(uart_txd), 32'h1);
    check("rst_async_busy", 32'(tx_busy), 32'h0);
    tick(3);
    reset = 1'b0;
    check("rst_ovf_clr",  32'(tx_overflow), 32'h0);
    check("rst_ferr_clr", 32'(rx_frame_err), 32'h0);
    check("rst_char_clr", 32'(cpu_char_in), 32'h0);
    tick(12 * CPB);
    tx_q.delete(); tx_stop_q.delete(); tx_fall_q.delete();
    tx_low_cnt = 0;
    tick(30 * CPB);
    check("post_rst_frames", 32'(tx_q.size()), 32'd0);
    check("post_rst_low",    32'(tx_low_cnt), 32'd0);
    check("post_rst_busy",   32'(tx_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
